dff_mem_burst: RTL and testbench
================================

# dff_mem_burst

Parametrised flip-flop RAM with a command port, a registered read path, an auto-incrementing address pointer and a hardware clear sequencer. It is the next generation of the team's small DFF scratch memory. Width and depth are now generic, and command acceptance is governed by a valid/ready handshake. It sits between the pin-level command decoder and any block needing a few dozen bytes of local storage.

## Interface
- `DATA_W`, default 8: word width in bits.
- `ADDR_W`, default 4: address width; depth is `DEPTH = 2**ADDR_W` words.
- `CLEAR_ON_RESET`, default 1: 1 = run the clear sweep after reset; 0 = go straight to IDLE with contents undefined.

Ports:
- `clk`  in  1  sole clock; all state updates on the rising edge.
- `rst`  in  1  reset, synchronous and active-high.
- `cmd_valid`  in  1  a command is presented this cycle.
- `cmd_ready`  out  1  block accepts a command this cycle; high only in IDLE.
- `cmd_op`  in  2  command opcode: READ=00, WRITE=01, SETPTR=10, CLEAR=11.
- `cmd_use_ptr`  in  1  READ/WRITE address comes from the internal pointer, and the pointer post-increments.
- `cmd_addr`  in  ADDR_W  explicit address for READ/WRITE; also the load value for SETPTR.
- `wr_data`  in  DATA_W  write data for WRITE.
- `rd_valid`  out  1  one-cycle pulse; `rd_data` is valid this cycle.
- `rd_data`  out  DATA_W  read result; holds its last value between reads.
- `ptr`  out  ADDR_W  current pointer value.
- `busy`  out  1  high while the clear sweep runs; equal to `!cmd_ready`.

## Operation
- A command is accepted when `cmd_valid && cmd_ready` at a rising edge. No queueing; the command is ignored while `cmd_ready` is 0.
- Effective address: `cmd_use_ptr ? ptr : cmd_addr`.
- READ: `mem[eff]` is registered into `rd_data`. The pointer post-increments only when `cmd_use_ptr` is set.
- WRITE: `mem[eff] <= wr_data`. The pointer post-increments only when `cmd_use_ptr` is set.
- SETPTR: `ptr <= cmd_addr`. Memory is untouched and `rd_valid` stays 0.
- CLEAR: enter the CLEAR state.
- Pointer arithmetic is modulo DEPTH: the increment from DEPTH-1 wraps to 0 and no flag is raised.
- FSM has two states:
  - IDLE: accepts commands. A CLEAR op moves to CLEAR.
  - CLEAR: an internal counter `clr_idx` runs 0..DEPTH-1 and writes 0 to `mem[clr_idx]`, one word per cycle. After writing DEPTH-1 the FSM returns to IDLE. `ptr` is reset to 0 on entry.
- Reset sets:
  - `ptr = 0`, `rd_valid = 0`, `rd_data = 0`, `clr_idx = 0`.
  - State = CLEAR if `CLEAR_ON_RESET` is 1, else IDLE.
  - Memory contents are not reset directly; only the sweep zeroes them.
- Reset asserted mid-sweep restarts the sweep from address 0.
- Reset asserted the cycle a READ is accepted gives `rd_valid = 0` next cycle, and the read is lost.

## Timing
- READ accepted at edge N: `rd_valid = 1` with data during cycle N+1, so latency is 1. Back-to-back reads give one result per cycle.
- Write-then-read on consecutive cycles to the same address returns the newly written data; there is no bypass hazard.
- The clear sweep takes exactly DEPTH cycles. `cmd_ready` rises in the cycle after `mem[DEPTH-1]` is cleared.
  - With `CLEAR_ON_RESET = 1`, the first command can be accepted DEPTH cycles after reset deasserts.
- `cmd_ready` and `busy` are driven directly from the state register, with no combinational path from inputs.
- `ptr` updates on the accepting edge and is visible the next cycle.

## Structure
- Package `dff_mem_pkg` holds:
  - the opcode localparams `OP_READ`, `OP_WRITE`, `OP_SETPTR`, `OP_CLEAR`;
  - the state encoding `ST_IDLE`, `ST_CLEAR`.
- Sub-module `dff_mem_array`, parametrised by DATA_W/ADDR_W: one synchronous write port and one registered read port. It contains storage only. The top level holds the FSM, pointer and clear counter, and muxes the sweep write onto the array's write port.

## Test plan
- Reset with defaults, hold `cmd_valid = 1` READ addr 0. Required: `cmd_ready = 0` for 16 cycles, then accept; `rd_data = 0x00` with `rd_valid` one cycle later.
- WRITE 0xA5 to addr 3, then READ addr 3 on the next cycle. Required: `rd_valid` pulse with `rd_data = 0xA5` one cycle after the read is accepted.
- SETPTR 14, then four WRITEs with `cmd_use_ptr`, data 1, 2, 3, 4. Required: addresses 14, 15, 0, 1 hold 1, 2, 3, 4; `ptr = 2` afterwards (wrap).
- Fill all 16 words with nonzero data, issue CLEAR, then read all 16 words. Required: `busy` high for 16 cycles and every read returns 0x00.
- Assert `rst` for one cycle at sweep cycle 7. Required: the sweep restarts and `cmd_ready` rises 16 cycles after `rst` falls.
- Instantiate DATA_W=16, ADDR_W=6, CLEAR_ON_RESET=0. Required: `cmd_ready = 1` immediately after reset; WRITE/READ of 0xBEEF at addr 63 round-trips.

Source files
------------

// File: rtl/dff_mem_pkg.sv
// Shared opcode and FSM state encodings for the flip-flop burst memory.
package dff_mem_pkg;
    localparam logic [1:0] OP_READ   = 2'b00;
    localparam logic [1:0] OP_WRITE  = 2'b01;
    localparam logic [1:0] OP_SETPTR = 2'b10;
    localparam logic [1:0] OP_CLEAR  = 2'b11;

    localparam logic [0:0] ST_IDLE   = 1'b0;
    localparam logic [0:0] ST_CLEAR  = 1'b1;
endpackage

// File: rtl/dff_mem_array.sv
// Storage only: one synchronous write port and one registered read port.
module dff_mem_array #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic              re_i,
    input  logic [ADDR_W-1:0] raddr_i,
    output logic [DATA_W-1:0] rdata_o
);
    localparam int DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] rdata_q;

    // Contents are deliberately not reset; the top-level sweep zeroes them.
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    // Read register holds its value between reads.
    always_ff @(posedge clk) begin
        if (rst) begin
            rdata_q <= '0;
        end else if (re_i) begin
            rdata_q <= mem_q[raddr_i];
        end
    end

    assign rdata_o = rdata_q;
endmodule

// File: rtl/dff_mem_burst.sv
// Command-driven DFF RAM: valid/ready command port, auto-increment pointer,
// one-cycle registered reads and a hardware clear sweep.
module dff_mem_burst
    import dff_mem_pkg::*;
#(
    parameter int DATA_W         = 8,
    parameter int ADDR_W         = 4,
    parameter bit CLEAR_ON_RESET = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [1:0]        cmd_op,
    input  logic              cmd_use_ptr,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic              rd_valid,
    output logic [DATA_W-1:0] rd_data,
    output logic [ADDR_W-1:0] ptr,
    output logic              busy
);
    localparam logic [ADDR_W-1:0] LAST_IDX = '1;
    localparam logic [0:0]        ST_RESET = CLEAR_ON_RESET ? ST_CLEAR : ST_IDLE;

    logic [0:0]        state_q, state_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d;
    logic [ADDR_W-1:0] clr_idx_q, clr_idx_d;
    logic              rd_valid_q, rd_valid_d;

    logic              accept;
    logic              in_clear;
    logic [ADDR_W-1:0] eff_addr;
    logic              mem_we;
    logic              mem_re;
    logic [ADDR_W-1:0] mem_waddr;
    logic [DATA_W-1:0] mem_wdata;

    assign in_clear = (state_q == ST_CLEAR);
    assign accept   = cmd_valid && !in_clear;
    assign eff_addr = cmd_use_ptr ? ptr_q : cmd_addr;

    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        clr_idx_d  = clr_idx_q;
        rd_valid_d = 1'b0;
        if (in_clear) begin
            if (clr_idx_q == LAST_IDX) begin
                state_d   = ST_IDLE;
                clr_idx_d = '0;
            end else begin
                clr_idx_d = ADDR_W'(clr_idx_q + 1'b1);
            end
        end else if (accept) begin
            case (cmd_op)
                OP_READ: begin
                    rd_valid_d = 1'b1;
                    if (cmd_use_ptr) ptr_d = ADDR_W'(ptr_q + 1'b1);
                end
                OP_WRITE: begin
                    if (cmd_use_ptr) ptr_d = ADDR_W'(ptr_q + 1'b1);
                end
                OP_SETPTR: ptr_d = cmd_addr;
                default: begin
                    state_d   = ST_CLEAR;
                    clr_idx_d = '0;
                    ptr_d     = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_RESET;
            ptr_q      <= '0;
            clr_idx_q  <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            clr_idx_q  <= clr_idx_d;
            rd_valid_q <= rd_valid_d;
        end
    end

    // The sweep owns the write port while clearing; writes are suppressed in reset.
    assign mem_we    = !rst && (in_clear || (accept && cmd_op == OP_WRITE));
    assign mem_waddr = in_clear ? clr_idx_q : eff_addr;
    assign mem_wdata = in_clear ? '0 : wr_data;
    assign mem_re    = !rst && accept && (cmd_op == OP_READ);

    dff_mem_array #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_array (
        .clk     (clk),
        .rst     (rst),
        .we_i    (mem_we),
        .waddr_i (mem_waddr),
        .wdata_i (mem_wdata),
        .re_i    (mem_re),
        .raddr_i (eff_addr),
        .rdata_o (rd_data)
    );

    assign cmd_ready = !in_clear;
    assign busy      = in_clear;
    assign rd_valid  = rd_valid_q;
    assign ptr       = ptr_q;
endmodule

// File: tb/tb_dff_mem_burst.sv
// Directed, table-driven bench for dff_mem_burst (default and wide/no-clear builds).
module tb_dff_mem_burst;
    import dff_mem_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [1:0] cmd_op;
    logic       cmd_use_ptr;
    logic [3:0] cmd_addr;
    logic [7:0] wr_data;
    logic       rd_valid;
    logic [7:0] rd_data;
    logic [3:0] ptr;
    logic       busy;

    logic        rst2;
    logic        cmd_valid2;
    logic        cmd_ready2;
    logic [1:0]  cmd_op2;
    logic        cmd_use_ptr2;
    logic [5:0]  cmd_addr2;
    logic [15:0] wr_data2;
    logic        rd_valid2;
    logic [15:0] rd_data2;
    logic [5:0]  ptr2;
    logic        busy2;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    dff_mem_burst dut (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_use_ptr(cmd_use_ptr), .cmd_addr(cmd_addr),
        .wr_data(wr_data), .rd_valid(rd_valid), .rd_data(rd_data),
        .ptr(ptr), .busy(busy)
    );

    dff_mem_burst #(.DATA_W(16), .ADDR_W(6), .CLEAR_ON_RESET(1'b0)) dut2 (
        .clk(clk), .rst(rst2), .cmd_valid(cmd_valid2), .cmd_ready(cmd_ready2),
        .cmd_op(cmd_op2), .cmd_use_ptr(cmd_use_ptr2), .cmd_addr(cmd_addr2),
        .wr_data(wr_data2), .rd_valid(rd_valid2), .rd_data(rd_data2),
        .ptr(ptr2), .busy(busy2)
    );

    typedef struct {
        logic [1:0] op;
        logic       use_ptr;
        logic [3:0] addr;
        logic [7:0] wdata;
        logic       exp_rv;
        logic [7:0] exp_rd;
        logic [3:0] exp_ptr;
    } vec_t;

    vec_t vecs [16];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [1:0] op, input logic use_p,
                         input logic [3:0] addr, input logic [7:0] data);
        cmd_op = op; cmd_use_ptr = use_p; cmd_addr = addr; wr_data = data;
        cmd_valid = 1'b1;
        tick();
        cmd_valid = 1'b0;
    endtask

    task automatic issue2(input logic [1:0] op, input logic use_p,
                          input logic [5:0] addr, input logic [15:0] data);
        cmd_op2 = op; cmd_use_ptr2 = use_p; cmd_addr2 = addr; wr_data2 = data;
        cmd_valid2 = 1'b1;
        tick();
        cmd_valid2 = 1'b0;
    endtask

    // Counts samples (taken 1 time unit after each edge) while busy is high.
    task automatic count_busy(output int cnt);
        cnt = 0;
        while (busy && cnt < 100) begin
            cnt++;
            tick();
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int cnt;

        vecs[0]  = '{OP_WRITE,  1'b0, 4'd3,  8'hA5, 1'b0, 8'h00, 4'd0};
        vecs[1]  = '{OP_READ,   1'b0, 4'd3,  8'h00, 1'b1, 8'hA5, 4'd0};
        vecs[2]  = '{OP_SETPTR, 1'b0, 4'd14, 8'h00, 1'b0, 8'hA5, 4'd14};
        vecs[3]  = '{OP_WRITE,  1'b1, 4'd0,  8'h01, 1'b0, 8'hA5, 4'd15};
        vecs[4]  = '{OP_WRITE,  1'b1, 4'd0,  8'h02, 1'b0, 8'hA5, 4'd0};
        vecs[5]  = '{OP_WRITE,  1'b1, 4'd0,  8'h03, 1'b0, 8'hA5, 4'd1};
        vecs[6]  = '{OP_WRITE,  1'b1, 4'd0,  8'h04, 1'b0, 8'hA5, 4'd2};
        vecs[7]  = '{OP_READ,   1'b0, 4'd14, 8'h00, 1'b1, 8'h01, 4'd2};
        vecs[8]  = '{OP_READ,   1'b0, 4'd15, 8'h00, 1'b1, 8'h02, 4'd2};
        vecs[9]  = '{OP_READ,   1'b0, 4'd0,  8'h00, 1'b1, 8'h03, 4'd2};
        vecs[10] = '{OP_READ,   1'b0, 4'd1,  8'h00, 1'b1, 8'h04, 4'd2};
        vecs[11] = '{OP_READ,   1'b1, 4'd9,  8'h00, 1'b1, 8'h00, 4'd3};
        vecs[12] = '{OP_SETPTR, 1'b0, 4'd15, 8'h00, 1'b0, 8'h00, 4'd15};
        vecs[13] = '{OP_READ,   1'b1, 4'd0,  8'h00, 1'b1, 8'h02, 4'd0};
        vecs[14] = '{OP_WRITE,  1'b0, 4'd2,  8'h5A, 1'b0, 8'h02, 4'd0};
        vecs[15] = '{OP_READ,   1'b0, 4'd2,  8'h00, 1'b1, 8'h5A, 4'd0};

        rst = 1'b1; cmd_valid = 1'b0; cmd_op = OP_READ; cmd_use_ptr = 1'b0;
        cmd_addr = '0; wr_data = '0;
        rst2 = 1'b1; cmd_valid2 = 1'b0; cmd_op2 = OP_READ; cmd_use_ptr2 = 1'b0;
        cmd_addr2 = '0; wr_data2 = '0;

        // Reset, then hold a READ of addr 0 until the post-reset sweep ends.
        tick();
        tick();
        chk("reset_ptr", 32'(ptr), 32'd0);
        chk("reset_rd_valid", 32'(rd_valid), 32'd0);
        chk("reset_rd_data", 32'(rd_data), 32'd0);
        chk("reset_busy", 32'(busy), 32'd1);
        rst = 1'b0;
        cmd_op = OP_READ; cmd_addr = 4'd0; cmd_valid = 1'b1;
        cnt = 0;
        while (!cmd_ready && cnt < 100) begin
            cnt++;
            tick();
        end
        $display("post-reset sweep: cmd_ready low for %0d cycles", cnt);
        chk("reset_sweep_len", 32'(cnt), 32'd16);
        tick();
        cmd_valid = 1'b0;
        chk("first_read_valid", 32'(rd_valid), 32'd1);
        chk("first_read_data", 32'(rd_data), 32'h00);

        for (int i = 0; i < 16; i++) begin
            chk("vec_ready", 32'(cmd_ready), 32'd1);
            issue(vecs[i].op, vecs[i].use_ptr, vecs[i].addr, vecs[i].wdata);
            $display("vec %0d: op=%0d use_ptr=%0d addr=%0d wdata=%02h -> rd_valid=%0d rd_data=%02h ptr=%0d",
                     i, vecs[i].op, vecs[i].use_ptr, vecs[i].addr, vecs[i].wdata,
                     rd_valid, rd_data, ptr);
            chk($sformatf("vec%0d_rd_valid", i), 32'(rd_valid), 32'(vecs[i].exp_rv));
            chk($sformatf("vec%0d_rd_data", i), 32'(rd_data), 32'(vecs[i].exp_rd));
            chk($sformatf("vec%0d_ptr", i), 32'(ptr), 32'(vecs[i].exp_ptr));
        end

        // Fill with nonzero data, CLEAR, then every word must read back as zero.
        issue(OP_SETPTR, 1'b0, 4'd5, 8'h00);
        for (int i = 0; i < 16; i++) begin
            issue(OP_WRITE, 1'b0, 4'(i), 8'(8'h10 + i));
        end
        issue(OP_READ, 1'b0, 4'd7, 8'h00);
        chk("fill_readback", 32'(rd_data), 32'h17);
        chk("fill_ptr", 32'(ptr), 32'd5);
        issue(OP_CLEAR, 1'b0, 4'd0, 8'h00);
        chk("clear_ptr_zero", 32'(ptr), 32'd0);
        chk("clear_ready_low", 32'(cmd_ready), 32'd0);
        count_busy(cnt);
        $display("CLEAR: busy high for %0d cycles", cnt);
        chk("clear_busy_len", 32'(cnt), 32'd16);
        for (int i = 0; i < 16; i++) begin
            issue(OP_READ, 1'b0, 4'(i), 8'h00);
            $display("post-clear read addr %0d -> rd_valid=%0d rd_data=%02h", i, rd_valid, rd_data);
            chk($sformatf("clear_rd%0d_valid", i), 32'(rd_valid), 32'd1);
            chk($sformatf("clear_rd%0d_data", i), 32'(rd_data), 32'h00);
        end

        // Reset at sweep cycle 7 restarts the full sweep.
        issue(OP_CLEAR, 1'b0, 4'd0, 8'h00);
        repeat (7) tick();
        chk("midsweep_busy", 32'(busy), 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        cnt = 0;
        while (!cmd_ready && cnt < 100) begin
            cnt++;
            tick();
        end
        $display("reset mid-sweep: cmd_ready low for %0d cycles after rst fell", cnt);
        chk("midsweep_restart_len", 32'(cnt), 32'd16);

        // A READ accepted together with reset is lost.
        issue(OP_WRITE, 1'b0, 4'd3, 8'h77);
        issue(OP_READ, 1'b0, 4'd3, 8'h00);
        chk("pre_rst_read", 32'(rd_data), 32'h77);
        cmd_op = OP_READ; cmd_addr = 4'd3; cmd_valid = 1'b1; rst = 1'b1;
        tick();
        cmd_valid = 1'b0; rst = 1'b0;
        $display("READ with rst: rd_valid=%0d rd_data=%02h", rd_valid, rd_data);
        chk("rst_read_lost_valid", 32'(rd_valid), 32'd0);
        chk("rst_read_lost_data", 32'(rd_data), 32'h00);
        count_busy(cnt);
        chk("rst_read_sweep_len", 32'(cnt), 32'd16);

        // Wide build without clear-on-reset.
        tick();
        chk("w_ready_after_reset", 32'(cmd_ready2), 32'd1);
        chk("w_busy_after_reset", 32'(busy2), 32'd0);
        rst2 = 1'b0;
        issue2(OP_WRITE, 1'b0, 6'd63, 16'hBEEF);
        issue2(OP_READ, 1'b0, 6'd63, 16'h0000);
        $display("wide READ addr 63 -> rd_valid=%0d rd_data=%04h", rd_valid2, rd_data2);
        chk("w_read_valid", 32'(rd_valid2), 32'd1);
        chk("w_read_data", 32'(rd_data2), 32'hBEEF);
        issue2(OP_SETPTR, 1'b0, 6'd63, 16'h0000);
        issue2(OP_WRITE, 1'b1, 6'd0, 16'h1234);
        chk("w_ptr_wrap", 32'(ptr2), 32'd0);
        issue2(OP_READ, 1'b0, 6'd63, 16'h0000);
        $display("wide READ addr 63 after ptr write -> rd_data=%04h", rd_data2);
        chk("w_ptr_write_data", 32'(rd_data2), 32'h1234);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
